sram_banked_dp: RTL and testbench
=================================

SRAM_BANKED_DP -- requirements
Module: sram_banked_dp

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 32768, total capacity in bytes.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits; must be a multiple of 8.
REQ-003 SHALL have parameter NUM_BANKS, default 2, number of word-interleaved banks; must be a power of 2 and at least 1.
REQ-004 SHALL have parameter NUM_WORDS, default RAM_SIZE/(DATA_WIDTH/8), total word count.
REQ-005 SHALL have parameter ADDR_WIDTH, default $clog2(NUM_WORDS), word address width.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-008 SHALL have, for each port P in {a, b}: P_req, input, 1, access request.
REQ-009 SHALL have P_gnt, output, 1, request accepted this cycle.
REQ-010 SHALL have P_addr, input, ADDR_WIDTH, word address.
REQ-011 SHALL have P_we, input, 1, write when 1, read when 0.
REQ-012 SHALL have P_be, input, DATA_WIDTH/8, byte enables.
REQ-013 SHALL have P_wdata, input, DATA_WIDTH, write data.
REQ-014 SHALL have P_rvalid, output, 1, response for the access granted on the previous cycle.
REQ-015 SHALL have P_rdata, output, DATA_WIDTH, read data, qualified by P_rvalid.
REQ-016 SHALL have port init_done, output, 1, memory ready for accesses.

Function
REQ-017 SHALL select the bank from P_addr[$clog2(NUM_BANKS)-1:0] and the row from the remaining upper bits; with NUM_BANKS=1 the whole address is the row.
REQ-018 SHALL drive P_gnt combinationally in the request cycle: P_gnt = P_req & init_done & (no bank conflict, or P wins arbitration).
REQ-019 SHALL treat as a bank conflict any cycle where a_req and b_req target the same bank, whether reading or writing.
REQ-020 SHALL arbitrate conflicts with a 1-bit round-robin priority register: the winner is granted, the loser holds P_gnt=0, and priority flips to the loser after each conflict.
REQ-021 SHALL leave the priority register unchanged in cycles without a conflict.
REQ-022 SHALL grant both ports in the same cycle when they target different banks.
REQ-023 SHALL perform a granted write at the clock edge, updating only the bytes whose P_be bit is 1.
REQ-024 SHALL assert P_rvalid exactly one cycle after each P_gnt, for reads and writes alike.
REQ-025 SHALL present P_rdata with P_rvalid: for a read, the full row contents before any write in the grant cycle; for a write, all zeros.
REQ-026 SHALL hold P_rdata stable while P_rvalid=0.
REQ-027 SHALL sustain one access per port per cycle when there is no conflict (back-to-back grants).

Reset
REQ-028 SHALL, while rst_n=0 at a clock edge, clear a_rvalid, b_rvalid, a_rdata, b_rdata and the priority register; priority goes to port a.
REQ-029 SHALL keep a_gnt and b_gnt at 0 in any cycle where rst_n=0.
REQ-030 SHALL not reset memory contents through rst_n; contents are affected only by the zero-init sweep (REQ-031).

Configuration
REQ-031 SHALL, with macro SRAM_ZERO_INIT_EN defined, run a two-state FSM {INIT, RUN}:
- Reset enters INIT and clears the row counter.
- In INIT, row counter r is written with zeros in every bank, all bytes, once per cycle; both P_gnt are held at 0.
- INIT goes to RUN after row NUM_WORDS/NUM_BANKS-1 is written.
- init_done is 1 only in RUN.
- A reset during INIT restarts the sweep at row 0.
REQ-032 SHALL, without SRAM_ZERO_INIT_EN, omit the FSM and counter: init_done=1 in every cycle after reset is released, and initial memory contents are undefined.

Verification
REQ-033 Scenario: defaults, SRAM_ZERO_INIT_EN defined, release reset -> init_done rises after exactly 4096 cycles; then a read of addr 0x0123 returns 0x00000000.
REQ-034 Scenario: a writes 0xDEADBEEF to addr 5 with be=4'b1111; then a writes 0x000000AA to addr 5 with be=4'b0001; then a reads addr 5 -> rvalid one cycle after gnt, rdata=0xDEADBEAA.
REQ-035 Scenario: a reads addr 2 and b reads addr 4 in the same cycle (both bank 0), repeated for 3 cycles -> grants go a, b, a; each loser is granted the following cycle.
REQ-036 Scenario: a addr 2 and b addr 3 (different banks), 8 consecutive cycles -> both gnt=1 every cycle and 8 rvalids on each port.
REQ-037 Scenario: reset pulsed for 1 cycle at INIT row 100 -> the sweep restarts at row 0 and init_done rises 4096 cycles after reset release.
REQ-038 Scenario: without SRAM_ZERO_INIT_EN, request a read of addr 7 on the first cycle after reset release -> gnt=1 immediately and rvalid on the next cycle.

Source files
------------

// File: rtl/sram_banked_dp_if.sv
// sram_banked_dp_if: one access port of the banked dual-port SRAM.
// The master drives requests. The slave (the memory) returns the grant and the response.
interface sram_banked_dp_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_banked_dp.sv
// sram_banked_dp: word-interleaved, multi-bank SRAM with two access ports (a, b).
// Both ports can be granted in the same cycle when they address different banks.
// When both ports address the same bank, a 1-bit round-robin register picks the winner.
// Every grant gets a response one cycle later: read data for a read, zeros for a write.
// Optional macro SRAM_ZERO_INIT_EN: after reset, sweep every row to zero before
// init_done rises.
module sram_banked_dp #(
  parameter int RAM_SIZE   = 32768,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 2,
  parameter int NUM_WORDS  = RAM_SIZE / (DATA_WIDTH / 8),
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_banked_dp_if.slave       a,
  sram_banked_dp_if.slave       b,
  output logic                  init_done
);
  localparam int NB        = DATA_WIDTH / 8;
  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W     = ADDR_WIDTH - BANK_BITS;
  localparam int ROWS      = NUM_WORDS / NUM_BANKS;

  logic [BANK_W-1:0]     a_bank, b_bank;
  logic [ROW_W-1:0]      a_row, b_row;
  logic                  conflict;
  logic                  a_gnt, b_gnt;
  logic                  prio_q, prio_d;
  logic                  a_rvalid_q, b_rvalid_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];
  logic                  init_wr;
  logic [ROW_W-1:0]      init_row;

  // Bank = low address bits, row = remaining upper bits
  if (NUM_BANKS == 1) begin : g_one_bank
    assign a_bank = '0;
    assign b_bank = '0;
    assign a_row  = a.addr;
    assign b_row  = b.addr;
  end else begin : g_multi_bank
    assign a_bank = a.addr[BANK_BITS-1:0];
    assign b_bank = b.addr[BANK_BITS-1:0];
    assign a_row  = a.addr[ADDR_WIDTH-1:BANK_BITS];
    assign b_row  = b.addr[ADDR_WIDTH-1:BANK_BITS];
  end

`ifdef SRAM_ZERO_INIT_EN
  typedef enum logic {S_INIT, S_RUN} state_e;
  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;

  // State register: reset restarts the zero sweep at row 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Next state: advance one row per cycle; leave INIT after the last row
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    if (state_q == S_INIT) begin
      row_d = row_q + ROW_W'(1);
      if (row_q == ROW_W'(ROWS - 1)) state_d = S_RUN;
    end
  end

  // Outputs: while in INIT, zero the current row in every bank
  always_comb begin
    init_done = (state_q == S_RUN);
    init_wr   = (state_q == S_INIT) & rst_n;
    init_row  = row_q;
  end
`else
  // Without the zero sweep, the memory is ready as soon as reset is released
  always_comb begin
    init_done = rst_n;
    init_wr   = 1'b0;
    init_row  = '0;
  end
`endif

  assign conflict = a.req & b.req & (a_bank == b_bank);
  assign a_gnt    = rst_n & init_done & a.req & (~conflict | ~prio_q);
  assign b_gnt    = rst_n & init_done & b.req & (~conflict |  prio_q);
  assign a.gnt    = a_gnt;
  assign b.gnt    = b_gnt;

  // Next-state logic: the round-robin flips only on a conflict that is arbitrated.
  // Read data is captured only on a grant and held otherwise.
  always_comb begin
    prio_d    = (rst_n & init_done & conflict) ? ~prio_q : prio_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_gnt) a_rdata_d = a.we ? '0 : bank_rd[a_bank];
    if (b_gnt) b_rdata_d = b.we ? '0 : bank_rd[b_bank];
  end

  // Response registers and arbitration priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      prio_q     <= prio_d;
      a_rvalid_q <= a_gnt;
      b_rvalid_q <= b_gnt;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a.rvalid = a_rvalid_q;
  assign b.rvalid = b_rvalid_q;
  assign a.rdata  = a_rdata_q;
  assign b.rdata  = b_rdata_q;

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem_q [ROWS];
    logic                  sel_a, sel_b, wr_en;
    logic [ROW_W-1:0]      row;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] wdata;

    // Bank port mux: arbitration guarantees at most one granted port per bank
    always_comb begin
      sel_a = a_gnt & (a_bank == BANK_W'(k));
      sel_b = b_gnt & (b_bank == BANK_W'(k));
      row   = a_row;
      be    = a.be;
      wdata = a.wdata;
      wr_en = sel_a & a.we;
      if (sel_b) begin
        row   = b_row;
        be    = b.be;
        wdata = b.wdata;
        wr_en = b.we;
      end
    end

    // Storage: the zero sweep, or a byte-masked write; no reset on contents
    always_ff @(posedge clk) begin
      if (init_wr) begin
        mem_q[init_row] <= '0;
      end else if (wr_en) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (be[i]) mem_q[row][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end

    assign bank_rd[k] = mem_q[row];
  end

endmodule

// File: tb/tb_sram_banked_dp.sv
// tb_sram_banked_dp: directed checks of sram_banked_dp with its default parameters.
// Build with or without SRAM_ZERO_INIT_EN, matching the DUT build.
module tb_sram_banked_dp;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int NB = DW / 8;

`ifdef SRAM_ZERO_INIT_EN
  localparam logic [DW-1:0] EXP_ADDR2 = 32'h0000_0000;
  localparam logic [DW-1:0] EXP_ADDR5 = 32'h0000_0000;
`else
  localparam logic [DW-1:0] EXP_ADDR2 = 32'h2222_2222;
  localparam logic [DW-1:0] EXP_ADDR5 = 32'hDE66_77AA;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic init_done;
  int   checks = 0;
  int   errors = 0;
  int   n, ca, cb;

  always #5 clk = ~clk;

  sram_banked_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a_bus ();
  sram_banked_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_bus ();

  sram_banked_dp #(
    .RAM_SIZE  (32768),
    .DATA_WIDTH(DW),
    .NUM_BANKS (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a_bus),
    .b        (b_bus),
    .init_done(init_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_bus.req = 1'b0; a_bus.we = 1'b0; a_bus.addr = '0; a_bus.be = '0; a_bus.wdata = '0;
  endtask

  task automatic idle_b();
    b_bus.req = 1'b0; b_bus.we = 1'b0; b_bus.addr = '0; b_bus.be = '0; b_bus.wdata = '0;
  endtask

  task automatic set_a(input logic we, input logic [AW-1:0] ad, input logic [NB-1:0] be,
                       input logic [DW-1:0] d);
    a_bus.req = 1'b1; a_bus.we = we; a_bus.addr = ad; a_bus.be = be; a_bus.wdata = d;
  endtask

  task automatic set_b(input logic we, input logic [AW-1:0] ad, input logic [NB-1:0] be,
                       input logic [DW-1:0] d);
    b_bus.req = 1'b1; b_bus.we = we; b_bus.addr = ad; b_bus.be = be; b_bus.wdata = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_a();
    idle_b();
    set_a(1'b0, 13'd7, 4'hF, 32'h0);
    set_b(1'b0, 13'd8, 4'hF, 32'h0);
    repeat (3) tick();
    #2;
    chk("gnt_a_in_reset", a_bus.gnt, 0);
    chk("gnt_b_in_reset", b_bus.gnt, 0);
    chk("rvalid_a_reset", a_bus.rvalid, 0);
    chk("rvalid_b_reset", b_bus.rvalid, 0);
    chk("rdata_a_reset", a_bus.rdata, 0);
    chk("rdata_b_reset", b_bus.rdata, 0);
    idle_b();

`ifdef SRAM_ZERO_INIT_EN
    chk("init_done_in_reset", init_done, 0);
    idle_a();
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 5000) begin
      tick();
      n++;
    end
    chk("init_cycles", n, 4096);
    set_a(1'b0, 13'h0123, 4'hF, 32'h0);
    #2 chk("gnt_read_0123", a_bus.gnt, 1);
    tick();
    chk("rvalid_read_0123", a_bus.rvalid, 1);
    chk("rdata_read_0123", a_bus.rdata, 32'h0);
`else
    rst_n = 1'b1;
    #2;
    chk("init_done_after_release", init_done, 1);
    chk("gnt_first_cycle", a_bus.gnt, 1);
    tick();
    chk("rvalid_first_cycle", a_bus.rvalid, 1);
`endif

    // Full write, byte-masked write, read back through port a
    set_a(1'b1, 13'd5, 4'hF, 32'hDEADBEEF);
    #2 chk("gnt_wr_full", a_bus.gnt, 1);
    tick();
    chk("rvalid_wr_full", a_bus.rvalid, 1);
    chk("rdata_wr_zero", a_bus.rdata, 32'h0);
    set_a(1'b1, 13'd5, 4'h1, 32'h000000AA);
    #2 chk("gnt_wr_byte", a_bus.gnt, 1);
    tick();
    chk("rvalid_wr_byte", a_bus.rvalid, 1);
    set_a(1'b0, 13'd5, 4'h0, 32'h0);
    #2 chk("gnt_rd5", a_bus.gnt, 1);
    tick();
    chk("rvalid_rd5", a_bus.rvalid, 1);
    chk("rdata_rd5", a_bus.rdata, 32'hDEADBEAA);
    idle_a();
    tick();
    chk("rvalid_idle", a_bus.rvalid, 0);
    chk("rdata_hold", a_bus.rdata, 32'hDEADBEAA);

    // Middle-bytes write and read back through port b
    set_b(1'b1, 13'd5, 4'b0110, 32'h55667788);
    #2 chk("gnt_b_wr_mid", b_bus.gnt, 1);
    tick();
    chk("rdata_b_wr_zero", b_bus.rdata, 32'h0);
    set_b(1'b0, 13'd5, 4'h0, 32'h0);
    #2;
    tick();
    chk("rvalid_b_rd5", b_bus.rvalid, 1);
    chk("rdata_b_rd5", b_bus.rdata, 32'hDE6677AA);

    // Preload: simultaneous writes to different banks, then one more write in bank 0
    set_a(1'b1, 13'd2, 4'hF, 32'h22222222);
    set_b(1'b1, 13'd3, 4'hF, 32'h33333333);
    #2;
    chk("gnt_a_dual_wr", a_bus.gnt, 1);
    chk("gnt_b_dual_wr", b_bus.gnt, 1);
    tick();
    set_a(1'b1, 13'd4, 4'hF, 32'h44444444);
    idle_b();
    #2;
    tick();

    // Same-bank conflict for 3 cycles: the grant goes to a, then b, then a
    set_a(1'b0, 13'd2, 4'h0, 32'h0);
    set_b(1'b0, 13'd4, 4'h0, 32'h0);
    #2;
    chk("rr1_gnt_a", a_bus.gnt, 1);
    chk("rr1_gnt_b", b_bus.gnt, 0);
    tick();
    chk("rr1_rdata_a", a_bus.rdata, 32'h22222222);
    chk("rr1_rvalid_b", b_bus.rvalid, 0);
    #2;
    chk("rr2_gnt_a", a_bus.gnt, 0);
    chk("rr2_gnt_b", b_bus.gnt, 1);
    tick();
    chk("rr2_rvalid_b", b_bus.rvalid, 1);
    chk("rr2_rdata_b", b_bus.rdata, 32'h44444444);
    chk("rr2_rvalid_a", a_bus.rvalid, 0);
    #2;
    chk("rr3_gnt_a", a_bus.gnt, 1);
    chk("rr3_gnt_b", b_bus.gnt, 0);
    tick();
    chk("rr3_rvalid_a", a_bus.rvalid, 1);

    // Different banks: both ports granted for 8 consecutive cycles
    set_b(1'b0, 13'd3, 4'h0, 32'h0);
    ca = 0;
    cb = 0;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("b2b_gnt_a", a_bus.gnt, 1);
      chk("b2b_gnt_b", b_bus.gnt, 1);
      tick();
      if (a_bus.rvalid) ca++;
      if (b_bus.rvalid) cb++;
    end
    chk("b2b_count_a", ca, 8);
    chk("b2b_count_b", cb, 8);
    chk("b2b_rdata_a", a_bus.rdata, 32'h22222222);
    chk("b2b_rdata_b", b_bus.rdata, 32'h33333333);

    // Priority holds across conflict-free cycles (b is due), then moves back to a
    set_b(1'b0, 13'd4, 4'h0, 32'h0);
    #2;
    chk("prio_kept_gnt_a", a_bus.gnt, 0);
    chk("prio_kept_gnt_b", b_bus.gnt, 1);
    tick();
    #2;
    chk("rr4_gnt_a", a_bus.gnt, 1);
    chk("rr4_gnt_b", b_bus.gnt, 0);
    tick();
    idle_a();
    idle_b();

    // Reset: clears the response registers and the priority (b was due next)
    rst_n = 1'b0;
    tick();
    chk("rdata_a_cleared", a_bus.rdata, 0);
    chk("rvalid_a_cleared", a_bus.rvalid, 0);
`ifdef SRAM_ZERO_INIT_EN
    rst_n = 1'b1;
    repeat (100) tick();
    set_a(1'b0, 13'd2, 4'h0, 32'h0);
    #2 chk("gnt_in_init", a_bus.gnt, 0);
    idle_a();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 5000) begin
      tick();
      n++;
    end
    chk("init_restart_cycles", n, 4096);
`else
    rst_n = 1'b1;
`endif
    set_a(1'b0, 13'd2, 4'h0, 32'h0);
    set_b(1'b0, 13'd4, 4'h0, 32'h0);
    #2;
    chk("prio_reset_gnt_a", a_bus.gnt, 1);
    chk("prio_reset_gnt_b", b_bus.gnt, 0);
    tick();
    chk("post_reset_rdata_a2", a_bus.rdata, EXP_ADDR2);
    idle_a();
    set_b(1'b0, 13'd5, 4'h0, 32'h0);
    #2;
    tick();
    chk("post_reset_rdata_b5", b_bus.rdata, EXP_ADDR5);
    idle_b();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
